// File: rtl/write_port_scheduler.sv
// Shares the sample-memory write port between ch0/ch1, round-robin per completed address group.
// Strobe/address/data appear one cycle after acceptance; ready is held low while mem_busy, nothing is buffered.
module write_port_scheduler #(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 16,
  parameter int                BEATS_PER_ADDR = 6,
  parameter logic [ADDR_W-1:0] CH0_BASE       = 16'h0000,
  parameter logic [ADDR_W-1:0] CH1_BASE       = 16'h8000,
  parameter logic [ADDR_W-1:0] CH_SIZE        = 16'h8000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_clear,
  input  logic                     ch0_valid,
  input  logic [DATA_W-1:0]        ch0_data,
  output logic                     ch0_ready,
  input  logic                     ch1_valid,
  input  logic [DATA_W-1:0]        ch1_data,
  output logic                     ch1_ready,
  input  logic                     mem_busy,
  output logic                     mem_write_ready,
  output logic [ADDR_W-1:0]        mem_address,
  output logic signed [DATA_W+7:0] mem_data,
  output logic                     grant,
  output logic [1:0]               wrap_flag
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam int                CNT_W     = (BEATS_PER_ADDR > 1) ? $clog2(BEATS_PER_ADDR) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS_PER_ADDR - 1);
  localparam logic [ADDR_W-1:0] LAST_OFF  = CH_SIZE - 1'b1;

  logic [0:0]        state;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt [2];
  logic [ADDR_W-1:0] off [2];

  logic              accept_ok;
  logic              accept;
  logic              sel_valid;
  logic              group_done;
  logic              next_grant;
  logic [CNT_W-1:0]  sel_cnt;
  logic [ADDR_W-1:0] sel_off;
  logic [ADDR_W-1:0] sel_base;
  logic [DATA_W-1:0] sel_data;

  // rst_n is folded in so ready is already low in the reset cycle itself
  assign accept_ok  = (state == BURST) & rst_n & ~mem_busy & ~cfg_clear;
  assign ch0_ready  = accept_ok & ~grant & ch0_valid;
  assign ch1_ready  = accept_ok &  grant & ch1_valid;
  assign accept     = ch0_ready | ch1_ready;

  assign sel_valid  = grant ? ch1_valid : ch0_valid;
  assign sel_data   = grant ? ch1_data  : ch0_data;
  assign sel_base   = grant ? CH1_BASE  : CH0_BASE;
  assign sel_cnt    = cnt[grant];
  assign sel_off    = off[grant];
  assign group_done = accept & (sel_cnt == LAST_BEAT);

  // Both requesting: alternate away from the last completed group; else the lone requester
  assign next_grant = (ch0_valid & ch1_valid) ? ~last_grant : ch1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n || cfg_clear) begin
      state           <= IDLE;
      grant           <= 1'b0;
      last_grant      <= 1'b1;
      cnt[0]          <= '0;
      cnt[1]          <= '0;
      off[0]          <= '0;
      off[1]          <= '0;
      wrap_flag       <= '0;
      mem_write_ready <= 1'b0;
      mem_address     <= '0;
      mem_data        <= '0;
    end else begin
      mem_write_ready <= accept;
      if (accept) begin
        mem_address <= sel_base + sel_off;
        mem_data    <= $signed({sel_data, 8'd0});
        if (group_done) begin
          cnt[grant] <= '0;
          last_grant <= grant;
          if (sel_off == LAST_OFF) begin
            off[grant]       <= '0;
            wrap_flag[grant] <= 1'b1;
          end else begin
            off[grant] <= sel_off + 1'b1;
          end
        end else begin
          cnt[grant] <= sel_cnt + 1'b1;
        end
      end

      // A dropped valid leaves the partial group's count and pointer for later resumption
      case (state)
        IDLE: begin
          if (ch0_valid || ch1_valid) begin
            grant <= next_grant;
            state <= BURST;
          end
        end
        BURST: begin
          if (!sel_valid || group_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_port_scheduler.sv
// Directed bench for write_port_scheduler: default-parameter instance plus a small wrap instance.
module tb_write_port_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cfg_clear, mem_busy;
  logic        ch0_valid, ch1_valid, ch0_ready, ch1_ready;
  logic [15:0] ch0_data, ch1_data;
  logic        mem_write_ready, grant;
  logic [15:0] mem_address;
  logic signed [23:0] mem_data;
  logic [1:0]  wrap_flag;

  logic        w_cfg_clear, w_mem_busy;
  logic        w_ch0_valid, w_ch1_valid, w_ch0_ready, w_ch1_ready;
  logic [15:0] w_ch0_data, w_ch1_data;
  logic        w_mem_write_ready, w_grant;
  logic [15:0] w_mem_address;
  logic signed [23:0] w_mem_data;
  logic [1:0]  w_wrap_flag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] s_addr[$];
  logic [23:0] s_data[$];
  int          s_cyc[$];
  logic        s_grant[$];
  logic [15:0] w_addr[$];
  int          w_cyc[$];
  logic [1:0]  w_wrap[$];

  write_port_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cfg_clear(cfg_clear),
    .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
    .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
    .mem_busy(mem_busy), .mem_write_ready(mem_write_ready),
    .mem_address(mem_address), .mem_data(mem_data),
    .grant(grant), .wrap_flag(wrap_flag)
  );

  write_port_scheduler #(.BEATS_PER_ADDR(1), .CH_SIZE(16'd4)) dut_w (
    .clk(clk), .rst_n(rst_n), .cfg_clear(w_cfg_clear),
    .ch0_valid(w_ch0_valid), .ch0_data(w_ch0_data), .ch0_ready(w_ch0_ready),
    .ch1_valid(w_ch1_valid), .ch1_data(w_ch1_data), .ch1_ready(w_ch1_ready),
    .mem_busy(w_mem_busy), .mem_write_ready(w_mem_write_ready),
    .mem_address(w_mem_address), .mem_data(w_mem_data),
    .grant(w_grant), .wrap_flag(w_wrap_flag)
  );

  // Advance one cycle and log any strobe produced by the previous cycle's acceptance
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_write_ready === 1'b1) begin
      s_addr.push_back(mem_address);
      s_data.push_back(mem_data);
      s_cyc.push_back(cyc);
      s_grant.push_back(grant);
    end
    if (w_mem_write_ready === 1'b1) begin
      w_addr.push_back(w_mem_address);
      w_cyc.push_back(cyc);
      w_wrap.push_back(w_wrap_flag);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_clear = 1'b0; mem_busy = 1'b0;
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    w_cfg_clear = 1'b0; w_mem_busy = 1'b0;
    w_ch0_valid = 1'b0; w_ch1_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cyc = 0;
    s_addr.delete(); s_data.delete(); s_cyc.delete(); s_grant.delete();
    w_addr.delete(); w_cyc.delete(); w_wrap.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_clear = 1'b0; mem_busy = 1'b0;
    ch0_valid = 1'b1; ch1_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_write_ready !== 1'b0) begin failures++; $display("FAIL rst_strobe got=%b exp=0", mem_write_ready); end
    checks++;
    if (mem_address !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h exp=0000", mem_address); end
    checks++;
    if (mem_data !== 24'h000000) begin failures++; $display("FAIL rst_data got=%h exp=000000", mem_data); end
    checks++;
    if ({grant, wrap_flag} !== 3'b000) begin failures++; $display("FAIL rst_grant_wrap got=%b exp=000", {grant, wrap_flag}); end
    checks++;
    if ({ch0_ready, ch1_ready} !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", {ch0_ready, ch1_ready}); end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({ch0_ready, ch1_ready} !== 2'b00) begin failures++; $display("FAIL idle_ready got=%b exp=00", {ch0_ready, ch1_ready}); end
    tick();
    checks++;
    if (grant !== 1'b0) begin failures++; $display("FAIL first_grant got=%b exp=0", grant); end
  endtask

  task automatic test_single_channel();
    logic [15:0] ea [7];
    int          ec [7];
    ea = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    ec = '{2, 3, 4, 5, 6, 7, 9};
    do_reset();
    ch0_data = 16'h1234;
    ch0_valid = 1'b1;
    while (s_addr.size() < 7 && cyc < 40) tick();
    ch0_valid = 1'b0;
    checks++;
    if (s_addr.size() != 7) begin failures++; $display("FAIL t1_count got=%0d exp=7", s_addr.size()); end
    for (int i = 0; i < 7 && i < s_addr.size(); i++) begin
      checks++;
      if (s_addr[i] !== ea[i]) begin failures++; $display("FAIL t1_addr[%0d] got=%h exp=%h", i, s_addr[i], ea[i]); end
      checks++;
      if (s_data[i] !== 24'h123400) begin failures++; $display("FAIL t1_data[%0d] got=%h exp=123400", i, s_data[i]); end
      checks++;
      if (s_cyc[i] != ec[i]) begin failures++; $display("FAIL t1_cycle[%0d] got=%0d exp=%0d", i, s_cyc[i], ec[i]); end
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_addr;
    logic [23:0] exp_data;
    int          g, exp_cyc;
    do_reset();
    ch0_data = 16'hA5A5;
    ch1_data = 16'h5A5A;
    ch0_valid = 1'b1;
    ch1_valid = 1'b1;
    while (s_addr.size() < 24 && cyc < 80) tick();
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    checks++;
    if (s_addr.size() != 24) begin failures++; $display("FAIL t2_count got=%0d exp=24", s_addr.size()); end
    for (int i = 0; i < 24 && i < s_addr.size(); i++) begin
      g = i / 6;
      exp_addr = ((g % 2) == 1) ? 16'h8000 + 16'(g / 2) : 16'(g / 2);
      exp_data = ((g % 2) == 1) ? 24'h5A5A00 : 24'hA5A500;
      exp_cyc  = 2 + 7 * g + (i % 6);
      checks++;
      if (s_addr[i] !== exp_addr) begin failures++; $display("FAIL t2_addr[%0d] got=%h exp=%h", i, s_addr[i], exp_addr); end
      checks++;
      if (s_data[i] !== exp_data) begin failures++; $display("FAIL t2_data[%0d] got=%h exp=%h", i, s_data[i], exp_data); end
      checks++;
      if (s_grant[i] !== 1'(g % 2)) begin failures++; $display("FAIL t2_grant[%0d] got=%b exp=%0d", i, s_grant[i], g % 2); end
      checks++;
      if (s_cyc[i] != exp_cyc) begin failures++; $display("FAIL t2_cycle[%0d] got=%0d exp=%0d", i, s_cyc[i], exp_cyc); end
    end
    tick();
  endtask

  task automatic test_mem_busy();
    logic [15:0] ea [7];
    int          ec [7];
    ea = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    ec = '{2, 3, 7, 8, 9, 10, 12};
    do_reset();
    ch0_data = 16'h0BEE;
    ch0_valid = 1'b1;
    while (s_addr.size() < 2 && cyc < 20) tick();
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ch0_ready !== 1'b0) begin failures++; $display("FAIL t3_busy_ready[%0d] got=%b exp=0", k, ch0_ready); end
      tick();
    end
    mem_busy = 1'b0;
    while (s_addr.size() < 7 && cyc < 40) tick();
    ch0_valid = 1'b0;
    checks++;
    if (s_addr.size() != 7) begin failures++; $display("FAIL t3_count got=%0d exp=7", s_addr.size()); end
    for (int i = 0; i < 7 && i < s_addr.size(); i++) begin
      checks++;
      if (s_addr[i] !== ea[i]) begin failures++; $display("FAIL t3_addr[%0d] got=%h exp=%h", i, s_addr[i], ea[i]); end
      checks++;
      if (s_cyc[i] != ec[i]) begin failures++; $display("FAIL t3_cycle[%0d] got=%0d exp=%0d", i, s_cyc[i], ec[i]); end
    end
    tick();
  endtask

  task automatic test_partial_resume();
    logic [15:0] ea [13];
    logic [23:0] ed [13];
    int          ec [13];
    ea = '{16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
           16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
    ed = '{24'h0C0C00, 24'h0C0C00, 24'h1C1C00, 24'h1C1C00, 24'h1C1C00, 24'h1C1C00, 24'h1C1C00,
           24'h1C1C00, 24'h0C0C00, 24'h0C0C00, 24'h0C0C00, 24'h0C0C00, 24'h0C0C00};
    ec = '{2, 3, 6, 7, 8, 9, 10, 11, 13, 14, 15, 16, 18};
    do_reset();
    ch0_data = 16'h0C0C;
    ch1_data = 16'h1C1C;
    ch0_valid = 1'b1;
    ch1_valid = 1'b1;
    while (s_addr.size() < 2 && cyc < 20) tick();
    ch0_valid = 1'b0;
    while (s_addr.size() < 8 && cyc < 40) tick();
    ch1_valid = 1'b0;
    ch0_valid = 1'b1;
    while (s_addr.size() < 13 && cyc < 60) tick();
    ch0_valid = 1'b0;
    checks++;
    if (s_addr.size() != 13) begin failures++; $display("FAIL t4_count got=%0d exp=13", s_addr.size()); end
    for (int i = 0; i < 13 && i < s_addr.size(); i++) begin
      checks++;
      if (s_addr[i] !== ea[i]) begin failures++; $display("FAIL t4_addr[%0d] got=%h exp=%h", i, s_addr[i], ea[i]); end
      checks++;
      if (s_data[i] !== ed[i]) begin failures++; $display("FAIL t4_data[%0d] got=%h exp=%h", i, s_data[i], ed[i]); end
      checks++;
      if (s_cyc[i] != ec[i]) begin failures++; $display("FAIL t4_cycle[%0d] got=%0d exp=%0d", i, s_cyc[i], ec[i]); end
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] ea [5];
    logic [1:0]  ew [5];
    int          ec [5];
    ea = '{16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h8000};
    ew = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
    ec = '{2, 4, 6, 8, 10};
    do_reset();
    w_ch1_data = 16'h00FF;
    w_ch1_valid = 1'b1;
    while (w_addr.size() < 5 && cyc < 40) tick();
    w_ch1_valid = 1'b0;
    checks++;
    if (w_addr.size() != 5) begin failures++; $display("FAIL t5_count got=%0d exp=5", w_addr.size()); end
    for (int i = 0; i < 5 && i < w_addr.size(); i++) begin
      checks++;
      if (w_addr[i] !== ea[i]) begin failures++; $display("FAIL t5_addr[%0d] got=%h exp=%h", i, w_addr[i], ea[i]); end
      checks++;
      if (w_wrap[i] !== ew[i]) begin failures++; $display("FAIL t5_wrap[%0d] got=%b exp=%b", i, w_wrap[i], ew[i]); end
      checks++;
      if (w_cyc[i] != ec[i]) begin failures++; $display("FAIL t5_cycle[%0d] got=%0d exp=%0d", i, w_cyc[i], ec[i]); end
    end
    tick();
    tick();
    tick();
    checks++;
    if (w_wrap_flag !== 2'b10) begin failures++; $display("FAIL t5_wrap_sticky got=%b exp=10", w_wrap_flag); end
  endtask

  task automatic test_clear();
    int ec [7];
    ec = '{7, 8, 9, 10, 11, 12, 14};
    // Clear the wrap instance while its sticky flag is still set from the previous scenario
    w_cfg_clear = 1'b1;
    tick();
    w_cfg_clear = 1'b0;
    checks++;
    if (w_wrap_flag !== 2'b00) begin failures++; $display("FAIL t6_wrap_clear got=%b exp=00", w_wrap_flag); end
    checks++;
    if (w_mem_address !== 16'h0000) begin failures++; $display("FAIL t6_wrap_addr got=%h exp=0000", w_mem_address); end

    do_reset();
    ch0_data = 16'h8001;
    ch0_valid = 1'b1;
    while (s_addr.size() < 3 && cyc < 20) tick();
    cfg_clear = 1'b1;
    #1;
    checks++;
    if (ch0_ready !== 1'b0) begin failures++; $display("FAIL t6_clear_ready got=%b exp=0", ch0_ready); end
    tick();
    cfg_clear = 1'b0;
    checks++;
    if (mem_write_ready !== 1'b0) begin failures++; $display("FAIL t6_clear_strobe got=%b exp=0", mem_write_ready); end
    checks++;
    if (mem_data !== 24'h000000) begin failures++; $display("FAIL t6_clear_data got=%h exp=000000", mem_data); end
    checks++;
    if ({grant, wrap_flag} !== 3'b000) begin failures++; $display("FAIL t6_clear_grant_wrap got=%b exp=000", {grant, wrap_flag}); end
    while (s_addr.size() < 10 && cyc < 40) tick();
    ch0_valid = 1'b0;
    checks++;
    if (s_addr.size() != 10) begin failures++; $display("FAIL t6_count got=%0d exp=10", s_addr.size()); end
    for (int i = 3; i < 10 && i < s_addr.size(); i++) begin
      checks++;
      if (s_addr[i] !== ((i == 9) ? 16'h0001 : 16'h0000)) begin
        failures++; $display("FAIL t6_addr[%0d] got=%h exp=%h", i, s_addr[i], (i == 9) ? 16'h0001 : 16'h0000);
      end
      checks++;
      if (s_data[i] !== 24'h800100) begin failures++; $display("FAIL t6_data[%0d] got=%h exp=800100", i, s_data[i]); end
      checks++;
      if (s_cyc[i] != ec[i-3]) begin failures++; $display("FAIL t6_cycle[%0d] got=%0d exp=%0d", i, s_cyc[i], ec[i-3]); end
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; cfg_clear = 1'b0; mem_busy = 1'b0;
    ch0_valid = 1'b0; ch1_valid = 1'b0; ch0_data = '0; ch1_data = '0;
    w_cfg_clear = 1'b0; w_mem_busy = 1'b0;
    w_ch0_valid = 1'b0; w_ch1_valid = 1'b0; w_ch0_data = '0; w_ch1_data = '0;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_mem_busy();
    test_partial_resume();
    test_wrap();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_port_scheduler.md
Name: write_port_scheduler

Overview:
- Shares the single sample-memory write port between two producer channels (ch0, ch1).
- Generates the write strobe, address and 24-bit padded data that the memory writer consumes.
- Each channel owns an address pointer in its own region. A pointer holds for BEATS_PER_ADDR accepted beats, then advances.
- Grant is round-robin per completed address group.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, producer sample width; memory data width is DATA_W+8.
- BEATS_PER_ADDR, 6, accepted beats per address before the pointer advances (≥1).
- CH0_BASE, 16'h0000, ch0 region base address.
- CH1_BASE, 16'h8000, ch1 region base address.
- CH_SIZE, 16'h8000, words per region (≥1); offset wraps at CH_SIZE.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_clear  in  1  synchronous restart of pointers/counters/flags.
- ch0_valid  in  1  ch0 has a sample.
- ch0_data  in  DATA_W  ch0 sample.
- ch0_ready  out  1  ch0 beat accepted this cycle (valid&ready).
- ch1_valid  in  1  ch1 has a sample.
- ch1_data  in  DATA_W  ch1 sample.
- ch1_ready  out  1  ch1 beat accepted this cycle.
- mem_busy  in  1  memory cannot take a write this cycle.
- mem_write_ready  out  1  one-cycle write strobe.
- mem_address  out  ADDR_W  write address.
- mem_data  out  DATA_W+8  write data = {data, 8'd0}, signed.
- grant  out  1  channel currently owning the port (0/1).
- wrap_flag  out  2  sticky per-channel region-wrap flag.

Behaviour:
- Reset (rst_n=0):
  - mem_write_ready=0, mem_address=0, mem_data=0, grant=0, wrap_flag=0, ch*_ready=0.
  - State IDLE; pointer offsets=0; per-channel beat counts=0; last_grant=1, so ch0 wins first.
- FSM states: IDLE, BURST.
  - IDLE: if either valid is high, pick a channel. If both are valid, pick the one ≠ last_grant; otherwise pick the single requester. Set grant and go to BURST. ready=0 in IDLE; arbitration costs one cycle.
  - BURST:
    - chX_ready = (grant==X) & chX_valid & ~mem_busy & ~cfg_clear. Combinational on those inputs; the other channel's ready is 0.
    - Granted valid low → return to IDLE next cycle. The channel's beat count and pointer are retained (partial group resumes later).
    - mem_busy high → no acceptance; stay in BURST.
- Accepted beat in cycle N:
  - Cycle N+1: mem_write_ready=1, mem_address = base[X] + offset[X], mem_data = {chX_data, 8'd0}.
  - mem_address/mem_data hold their value until the next accepted beat. mem_write_ready is 0 in every cycle not following an acceptance.
- Beat counting (per channel, independent):
  - Beat count < BEATS_PER_ADDR-1: count+1.
  - Beat count == BEATS_PER_ADDR-1: count←0, offset[X] advances, last_grant←X, FSM→IDLE (group complete, re-arbitrate).
- Wrap: when offset[X]==CH_SIZE-1 and it advances, offset←0 and wrap_flag[X]←1 (sticky). Address arithmetic is modulo 2^ADDR_W.
- cfg_clear=1 (rst_n=1): next cycle matches reset state; it overrides any acceptance in the same cycle.
- rst_n has priority over cfg_clear.
- Reset or clear mid-burst aborts the group; no strobe is issued for the aborted cycle.
- Back-to-back acceptance: one beat per cycle max → one strobe per cycle max.

Test Plan:
1. Reset; ch0_valid=1 with data 16'h1234 held for 7 beats; mem_busy=0 → 6 strobes at mem_address 0x0000, mem_data 0x123400. One idle arbitration cycle follows, then the 7th strobe is at 0x0001.
2. Both valid continuously → ch0 6×@0x0000, ch1 6×@0x8000, ch0 6×@0x0001, ch1 6×@0x8001. grant toggles per group.
3. ch0 bursting; mem_busy=1 for 3 cycles after beat 2 → ch0_ready=0 and no strobes for 3 cycles. Beats 3–6 then complete at 0x0000; the next group is at 0x0001.
4. ch0 valid drops after 2 beats while ch1 is valid → ch1 takes 6 beats @0x8000. ch0 later resumes with 4 beats @0x0000, then moves to 0x0001.
5. CH_SIZE=4, BEATS_PER_ADDR=1, ch1 only → addresses 0x8000, 0x8001, 0x8002, 0x8003, 0x8000. wrap_flag[1] goes to 1 after the 4th beat and stays set.
6. cfg_clear pulsed mid-group with ch0 valid → ch0_ready=0 that cycle, no strobe, wrap_flag=0. The next accepted beat writes 0x0000 as beat 0.
